// File: rtl/mem_arb_if.sv
// CPU, DMA and memory-side signal bundle for the mem_arb single-port memory arbiter.
// slave = the arbiter's view; master = the requester/memory side.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arb.sv
// CPU/DMA arbiter for one single-port data memory with WAIT_CYC extra access cycles.
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority; default build is round-robin.
module mem_arb #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          owner_q;
  logic          last_owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          any_req;
  logic          grant_dma;
  logic          access_end;

  assign any_req = bus.cpu_req | bus.dma_req;

`ifdef MEM_ARB_CPU_PRIO_EN
  assign grant_dma = bus.dma_req & ~bus.cpu_req;
`else
  // On a tie the requester that was not served last wins.
  assign grant_dma = bus.dma_req & (~bus.cpu_req | ~last_owner_q);
`endif

  assign access_end = (state_q == ACCESS) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting state_d first covers every path, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and per-requester read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments to avoid races.
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        owner_q <= grant_dma;
        we_q    <= grant_dma ? bus.dma_we    : bus.cpu_we;
        addr_q  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
        wdata_q <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
        cnt_q   <= CW'(WAIT_CYC);
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (access_end) begin
        last_owner_q <= owner_q;
        if (!we_q) begin
          if (owner_q) dma_rdata_q <= bus.mem_rdata;
          else         cpu_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = (state_q == DONE) && !owner_q;
  assign bus.dma_ack   = (state_q == DONE) && owner_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: table of single transactions plus hand-written
// sequences for arbitration, mid-access protocol abuse, reset abort and WAIT_CYC=0.
module tb_mem_arb;
  localparam int W = 1;

`ifdef MEM_ARB_CPU_PRIO_EN
  localparam logic [3:0] EXP_ORDER = 4'b0000;
`else
  localparam logic [3:0] EXP_ORDER = 4'b1010;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_if #(.AW(16), .DW(16)) bus ();
  mem_arb_if #(.AW(16), .DW(16)) bus0 ();

  mem_arb #(.AW(16), .DW(16), .WAIT_CYC(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_arb #(.AW(16), .DW(16), .WAIT_CYC(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // Memory model: combinational read while enabled, write on the rising edge.
  logic [15:0] tb_mem [0:4095];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 16'h0000;
      tb_mem[12'h010] <= 16'hBEEF;
      tb_mem[12'hFFF] <= 16'hA5A5;
    end else if (bus.mem_en && bus.mem_we) begin
      tb_mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata  = bus.mem_en  ? tb_mem[bus.mem_addr[11:0]] : 16'hDEAD;
  assign bus0.mem_rdata = bus0.mem_en ? ~bus0.mem_addr             : 16'hDEAD;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        exp_owner;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_cpu_rdata;
    logic [15:0] exp_dma_rdata;
  } vec_t;

  vec_t vecs [6];

  // Called on a falling edge; drives one request and follows it to its ack.
  task automatic run_txn(input vec_t v);
    int   en_cnt;
    int   ack_k;
    int   cpu_acks;
    int   dma_acks;
    logic bus_ok;
    en_cnt = 0; ack_k = -1; cpu_acks = 0; dma_acks = 0; bus_ok = 1'b1;
    bus.cpu_req = v.cpu_req; bus.cpu_we = v.cpu_we;
    bus.cpu_addr = v.cpu_addr; bus.cpu_wdata = v.cpu_wdata;
    bus.dma_req = v.dma_req; bus.dma_we = v.dma_we;
    bus.dma_addr = v.dma_addr; bus.dma_wdata = v.dma_wdata;
    for (int k = 1; k <= 12 && ack_k < 0; k++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        en_cnt++;
        if (bus.mem_addr !== v.exp_addr || bus.mem_we !== v.exp_we ||
            (v.exp_we && bus.mem_wdata !== v.exp_wdata)) bus_ok = 1'b0;
      end
      if (bus.cpu_ack === 1'b1) cpu_acks++;
      if (bus.dma_ack === 1'b1) dma_acks++;
      if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
        ack_k = k;
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
      end
    end
    @(negedge clk);
    if (bus.cpu_ack === 1'b1) cpu_acks++;
    if (bus.dma_ack === 1'b1) dma_acks++;
    if (bus.mem_en === 1'b1) en_cnt++;
    check({v.name, " ack latency"}, ack_k, W + 2);
    check({v.name, " mem_en cycles"}, en_cnt, W + 1);
    check({v.name, " mem bus fields"}, bus_ok, 1);
    check({v.name, " cpu_ack pulses"}, cpu_acks, v.exp_owner ? 0 : 1);
    check({v.name, " dma_ack pulses"}, dma_acks, v.exp_owner ? 1 : 0);
    check({v.name, " owner"}, bus.owner, v.exp_owner);
    check({v.name, " cpu_rdata"}, bus.cpu_rdata, v.exp_cpu_rdata);
    check({v.name, " dma_rdata"}, bus.dma_rdata, v.exp_dma_rdata);
    check({v.name, " busy after"}, bus.busy, 0);
  endtask

  initial begin
    int          n_ack;
    int          last_k;
    int          en_cnt;
    int          ack_k;
    int          cpu_acks;
    int          dma_acks;
    int          busy_seen;
    logic        ok;
    logic [3:0]  order;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.dma_req = 1'b0; bus0.dma_we = 1'b0; bus0.dma_addr = '0; bus0.dma_wdata = '0;
    rst_n = 1'b0;

    //            name      creq cwe caddr     cwdata    dreq dwe daddr     dwdata    own we  addr      wdata     cpu_rd    dma_rd
    vecs[0] = '{"cpu_rd0", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[1] = '{"dma_wr0", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b1, 1'b1, 16'h0200, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[2] = '{"dma_rd0", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[3] = '{"cpu_wr0", 1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h5555, 16'hBEEF, 16'h1234};
    vecs[4] = '{"cpu_rd1", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5555, 16'h1234};
    vecs[5] = '{"dma_rd1", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h5555, 16'hA5A5};

    repeat (3) @(negedge clk);
    check("reset mem_en", bus.mem_en, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset cpu_ack", bus.cpu_ack, 0);
    check("reset dma_ack", bus.dma_ack, 0);
    check("reset busy", bus.busy, 0);
    check("reset owner", bus.owner, 0);
    check("reset cpu_rdata", bus.cpu_rdata, 0);
    check("reset dma_rdata", bus.dma_rdata, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Both requesters held high for four grants.
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 16'h7777;
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    order = '0; n_ack = 0; last_k = 0; ok = 1'b1;
    for (int k = 1; k <= 60 && n_ack < 4; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1 && bus.dma_ack === 1'b1) ok = 1'b0;
      if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
        order[n_ack] = bus.dma_ack;
        if (n_ack > 0 && (k - last_k) != W + 3) ok = 1'b0;
        last_k = k;
        n_ack++;
      end
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    @(negedge clk);
    check("rr grants completed", n_ack, 4);
    check("rr grant order", order, EXP_ORDER);
    check("rr spacing and exclusivity", ok, 1);
    check("rr cpu_rdata", bus.cpu_rdata, 16'h5555);
    check("rr dma_rdata held over writes", bus.dma_rdata, 16'hA5A5);

    // CPU read whose address changes and req drops during ACCESS.
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1'b1;
    en_cnt = 0; cpu_acks = 0; dma_acks = 0; ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        en_cnt++;
        if (bus.mem_addr !== 16'h0010) ok = 1'b0;
      end
      if (bus.cpu_ack === 1'b1) cpu_acks++;
      if (bus.dma_ack === 1'b1) dma_acks++;
      if (k == 1) begin
        bus.cpu_addr = 16'h0FFF;
        bus.cpu_req  = 1'b0;
      end
    end
    check("abuse mem_en cycles", en_cnt, W + 1);
    check("abuse mem_addr held", ok, 1);
    check("abuse cpu_ack pulses", cpu_acks, 1);
    check("abuse dma_ack pulses", dma_acks, 0);
    check("abuse cpu_rdata", bus.cpu_rdata, 16'h5555);
    check("abuse busy after", bus.busy, 0);

    // Reset during a DMA write access.
    bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 16'hCAFE; bus.dma_req = 1'b1;
    @(negedge clk);
    check("rst access started mem_en", bus.mem_en, 1);
    check("rst access started mem_we", bus.mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst abort mem_en", bus.mem_en, 0);
    check("rst abort mem_we", bus.mem_we, 0);
    check("rst abort acks", {bus.cpu_ack, bus.dma_ack}, 0);
    bus.dma_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cpu_acks = 0; dma_acks = 0; busy_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) cpu_acks++;
      if (bus.dma_ack === 1'b1) dma_acks++;
      if (bus.busy !== 1'b0) busy_seen++;
    end
    check("rst no ack after release", cpu_acks + dma_acks, 0);
    check("rst busy after release", busy_seen, 0);
    check("rst owner after release", bus.owner, 0);

    // Zero-wait-state instance: single-cycle ACCESS.
    bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0044; bus0.cpu_req = 1'b1;
    en_cnt = 0; ack_k = -1; dma_acks = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus0.mem_en === 1'b1) en_cnt++;
      if (bus0.dma_ack === 1'b1) dma_acks++;
      if (bus0.cpu_ack === 1'b1 && ack_k < 0) begin
        ack_k = k;
        bus0.cpu_req = 1'b0;
      end
    end
    check("w0 mem_en cycles", en_cnt, 1);
    check("w0 ack latency", ack_k, 2);
    check("w0 cpu_rdata", bus0.cpu_rdata, 16'hFFBB);
    check("w0 dma_ack pulses", dma_acks, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates one single-port 16-bit data memory between two requesters: the CPU load/store path (driven by the control unit's LD/ST/IOR/IOW sequencing) and a DMA/IO engine.
- Each requester uses a req/ack handshake. The arbiter registers the winning request, drives the memory for a fixed, parameterised number of wait states, then returns a one-cycle ack with read data.

Parameters:
AW, 16, address width
DW, 16, data width
WAIT_CYC, 1, extra memory access cycles beyond the first; legal range 0..15

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data to CPU
cpu_ack  out  1  one-cycle completion pulse to CPU
dma_req  in  1  DMA access request, held high until dma_ack
dma_we  in  1  1 = write, 0 = read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  read data to DMA
dma_ack  out  1  one-cycle completion pulse to DMA
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid combinationally while mem_en=1
busy  out  1  high when state != IDLE
owner  out  1  current or last grantee: 0 = CPU, 1 = DMA

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wait counter=0, owner=0, last_owner=1 (so the CPU wins the first tie).
  - addr/wdata/we/rdata registers = 0.
  - All acks, mem_en and mem_we = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: select a winner, latch its we/addr/wdata, set owner, load counter=WAIT_CYC, go to ACCESS.
  - Round-robin selection: a lone requester wins. If both request, the one != last_owner wins.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata come from the latched registers only; input changes are ignored.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: on a read, capture mem_rdata into that owner's rdata register; set last_owner=owner; go to DONE.
  - ACCESS lasts exactly WAIT_CYC+1 cycles.
- DONE:
  - Exactly one of cpu_ack/dma_ack (the owner's) is high for one cycle; mem_en=0. Go to IDLE.
  - cpu_rdata/dma_rdata are registered. Each holds its last captured value until that requester's next read; writes do not alter it.
- Latency: with req sampled high in IDLE cycle t, ack is high in cycle t+WAIT_CYC+2. Back-to-back throughput is one access per WAIT_CYC+3 cycles.
- Handshake:
  - The requester drops req on the clock edge that samples ack=1.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
- Protocol violations:
  - req dropped during ACCESS: the access still completes and ack still pulses.
  - Inputs changed mid-access: ignored.
- Simultaneous requests arriving while busy: both are held and arbitrated in the next IDLE cycle.
- Reset asserted mid-access: the access is aborted with no ack. The memory may have seen a partial write cycle; software owns that hazard.
- WAIT_CYC=0 is legal: single-cycle ACCESS.

Optional Feature:
- Macro MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. The CPU always wins when both request; last_owner is not consulted, and the DMA can be starved.
- Undefined (default): round-robin as described under Behaviour.

Test Plan:
- Reset, then CPU read at addr 0x0010 with mem_rdata=0xBEEF, WAIT_CYC=1 -> mem_en high exactly 2 cycles with mem_addr=0x0010, mem_we=0; cpu_ack pulses in cycle t+3; cpu_rdata=0xBEEF; dma_ack stays 0.
- DMA write addr 0x0200 data 0x1234 -> mem_we=1, mem_addr=0x0200, mem_wdata=0x1234 for WAIT_CYC+1 cycles; single dma_ack pulse; cpu_rdata unchanged.
- cpu_req and dma_req both held high continuously for 4 transactions, each requester holding req across its ack -> grants alternate CPU, DMA, CPU, DMA. With MEM_ARB_CPU_PRIO_EN defined -> CPU wins all 4 and dma_ack is never asserted.
- CPU request granted; change cpu_addr 0x0010 to 0x0FFF and drop cpu_req during ACCESS -> mem_addr stays 0x0010; cpu_ack still pulses once.
- rst_n asserted during ACCESS of a DMA write -> mem_en, mem_we and the acks drop immediately; after release, busy=0 and no ack is issued for the aborted access.
- WAIT_CYC=0 build, CPU read -> mem_en high for 1 cycle; cpu_ack in cycle t+2.
